// File: rtl/argmax_classifier_if.sv
// Accelerator-to-host bundle for the argmax classifier: score snapshot input,
// class result handshake output and status flags.
interface argmax_classifier_if #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned IDX_W       = 4
);
  logic                          acc_ready;
  logic [NUM_CLASSES*DATA_W-1:0] results;
  logic                          class_ack;
  logic                          class_valid;
  logic [IDX_W-1:0]              class_id;
  logic [DATA_W-1:0]             class_score;
  logic                          busy;
  logic                          overrun;

  modport master (
    output acc_ready, results, class_ack,
    input  class_valid, class_id, class_score, busy, overrun
  );

  modport slave (
    input  acc_ready, results, class_ack,
    output class_valid, class_id, class_score, busy, overrun
  );
endinterface

// File: rtl/argmax_classifier.sv
// Snapshots the accelerator's signed class scores on a ready rising edge, scans
// them one per clock and reports the first-occurring maximum via valid/ack.
module argmax_classifier #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned IDX_W       = 4
) (
  input logic                clk,
  input logic                reset,
  argmax_classifier_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                   state;
  logic                     ready_q;
  logic                     start;
  logic                     do_capture;
  logic signed [DATA_W-1:0] snap [NUM_CLASSES];
  logic signed [DATA_W-1:0] best_val;
  logic [IDX_W-1:0]         best_idx;
  logic [IDX_W-1:0]         scan_idx;
  logic signed [DATA_W-1:0] nxt_val;
  logic [IDX_W-1:0]         nxt_idx;
  logic                     class_valid_r;
  logic [IDX_W-1:0]         class_id_r;
  logic [DATA_W-1:0]        class_score_r;
  logic                     overrun_r;

  assign start = bus.acc_ready & ~ready_q;
  // An ack in DONE frees the engine on the same edge, so a coincident start is taken.
  assign do_capture = start & ((state == IDLE) | ((state == DONE) & bus.class_ack));

  // Strict greater-than keeps the lowest index on ties.
  always_comb begin
    nxt_val = best_val;
    nxt_idx = best_idx;
    if (snap[scan_idx] > best_val) begin
      nxt_val = snap[scan_idx];
      nxt_idx = scan_idx;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      ready_q       <= 1'b1;
      best_val      <= '0;
      best_idx      <= '0;
      scan_idx      <= '0;
      class_valid_r <= 1'b0;
      class_id_r    <= '0;
      class_score_r <= '0;
      overrun_r     <= 1'b0;
      for (int unsigned k = 0; k < NUM_CLASSES; k++) snap[k] <= '0;
    end else begin
      ready_q <= bus.acc_ready;
      if (start && !do_capture && state != IDLE) overrun_r <= 1'b1;
      if (do_capture) begin
        for (int unsigned k = 0; k < NUM_CLASSES; k++)
          snap[k] <= bus.results[k*DATA_W +: DATA_W];
        best_val      <= bus.results[DATA_W-1:0];
        best_idx      <= '0;
        scan_idx      <= IDX_W'(1);
        class_valid_r <= 1'b0;
        state         <= SCAN;
      end else begin
        case (state)
          SCAN: begin
            best_val <= nxt_val;
            best_idx <= nxt_idx;
            scan_idx <= scan_idx + IDX_W'(1);
            if (scan_idx == IDX_W'(NUM_CLASSES - 1)) begin
              state         <= DONE;
              class_valid_r <= 1'b1;
              class_id_r    <= nxt_idx;
              class_score_r <= nxt_val;
            end
          end
          DONE: begin
            if (bus.class_ack) begin
              class_valid_r <= 1'b0;
              state         <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.class_valid = class_valid_r;
  assign bus.class_id    = class_id_r;
  assign bus.class_score = class_score_r;
  assign bus.overrun     = overrun_r;
  assign bus.busy        = (state != IDLE);

endmodule
